sm_mem_arbiter: RTL
===================

# sm_mem_arbiter

Shares one single-ported, variable-latency memory between the CPU instruction-fetch port and data port, for the von Neumann build of the pipelined core. Accepts one outstanding request per port, serialises them onto the memory bus with a 3-state FSM, and returns completion acks. The core stalls its F/M stages on missing acks.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- imReq  input  1  instruction read request; held until imAck
- imAddr  input  AW  instruction address; stable while imReq
- imData  output  DW  instruction read data; valid when imAck
- imAck  output  1  instruction transfer complete, one-cycle pulse
- dmReq  input  1  data request; held until dmAck
- dmWe  input  1  data write enable (1 = write); stable while dmReq
- dmAddr  input  AW  data address; stable while dmReq
- dmWData  input  DW  data write data; stable while dmReq
- dmRData  output  DW  data read data; valid when dmAck
- dmAck  output  1  data transfer complete, one-cycle pulse
- memReq  output  1  memory request; held until memAck
- memWe  output  1  memory write enable
- memAddr  output  AW  memory address
- memWData  output  DW  memory write data
- memRData  input  DW  memory read data; valid with memAck
- memAck  input  1  memory completion; may be asserted in the first memReq cycle
- arbErr  output  1  sticky protocol error

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- IDLE:
  - If no request, stay in IDLE.
  - If one port requests, go to that port's BUSY state.
  - If both request, the tie rule under Configuration decides.
- On grant, latch into registers:
  - the granted port's address, write enable and write data;
  - for imReq, memWe is latched as 0.
- BUSY_x:
  - memReq=1; memAddr, memWe and memWData come from the latch registers.
  - On memAck, return to IDLE.
- Acks:
  - imAck = memAck & (state==BUSY_I); dmAck = memAck & (state==BUSY_D).
  - Both are combinational, so the requester sees the ack in the same cycle as memAck.
- Read data:
  - During ack, imData/dmRData pass memRData through.
  - Otherwise each outputs its own hold register, updated on that port's ack.
  - Hold registers reset to 0. A write ack also updates dmRData's hold register with memRData; memory returns don't-care data on writes.
- A request arriving while the other port is BUSY waits in IDLE arbitration. Requests are never dropped.
- Error: arbErr is set when memAck=1 in IDLE. It clears only on reset, and the stray ack is otherwise ignored.

## Timing
- Reset values: memReq=0, memWe=0, memAddr=0, memWData=0, imAck=0, dmAck=0, imData=0, dmRData=0, arbErr=0.
- Latency: request sampled in IDLE at edge of cycle 0 → memReq=1 in cycle 1. With zero-wait memory (memAck in cycle 1), ack comes in cycle 1 and the FSM is in IDLE in cycle 2.
- Throughput: at most one transfer per 2 cycles. A requester seeing ack in cycle n may present a new request in cycle n+1. That request is granted at the end of n+1 and is on the bus in cycle n+2.
- memReq and all mem* outputs are registered-state driven and glitch-free. The only combinational paths are memAck/memRData → acks and read data.
- Reset mid-transfer: return to IDLE asynchronously and drop memReq immediately. The in-flight memory access is abandoned, and a later memAck counts as a stray ack (arbErr=1).

## Configuration
- SM_CONFIG_ARB_RR_EN defined: round-robin tie-break.
  - A lastGrant register tracks the last port served; on a tie, the port not served last wins.
  - lastGrant resets to D, so the first tie goes to I.
- Undefined: fixed priority, D wins every tie, and there is no lastGrant register. Rationale: the pipeline's M-stage drains before F, avoiding deadlock.

## Test plan
- Single read: imReq=1, imAddr=0x10, memory returns 0xDEADBEEF with memAck in the first memReq cycle → memReq=1 in cycle 1 with memAddr=0x10, memWe=0; imAck=1 and imData=0xDEADBEEF in cycle 1; IDLE in cycle 2; imData still 0xDEADBEEF in cycle 3.
- Write with 3-cycle memory latency: dmReq=1, dmWe=1, dmAddr=0x20, dmWData=0x1234 → memReq held for 3 cycles with stable memAddr=0x20 and memWData=0x1234; exactly one dmAck pulse; imAck stays 0.
- Continuous tie, both ports requesting for 4 transfers:
  - With SM_CONFIG_ARB_RR_EN, grant order is I, D, I, D.
  - Without it, grant order is D, D, D, D while dmReq stays high, and I is served only after dmReq drops.
- Request during busy: imReq granted; dmReq rises in the next cycle → data transfer starts on the bus exactly 2 cycles after imAck; no lost or duplicated acks.
- Async reset asserted mid-BUSY_D (memReq=1) → memReq=0 immediately; then memAck pulsed after reset release → arbErr=1, no dmAck.

Source files
------------

// File: rtl/sm_mem_arbiter_if.sv
// ============================================================================
// Module  : sm_mem_arbiter_if
// Brief   : CPU instruction/data request ports and shared memory bus bundle
//           for sm_mem_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface sm_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          imReq;
    logic [AW-1:0] imAddr;
    logic [DW-1:0] imData;
    logic          imAck;

    logic          dmReq;
    logic          dmWe;
    logic [AW-1:0] dmAddr;
    logic [DW-1:0] dmWData;
    logic [DW-1:0] dmRData;
    logic          dmAck;

    logic          memReq;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic [DW-1:0] memRData;
    logic          memAck;

    logic          arbErr;

    // Arbiter view
    modport slave (
        input  imReq, imAddr, dmReq, dmWe, dmAddr, dmWData, memRData, memAck,
        output imData, imAck, dmRData, dmAck, memReq, memWe, memAddr, memWData,
               arbErr
    );

    // Environment view: CPU ports plus memory
    modport master (
        output imReq, imAddr, dmReq, dmWe, dmAddr, dmWData, memRData, memAck,
        input  imData, imAck, dmRData, dmAck, memReq, memWe, memAddr, memWData,
               arbErr
    );
endinterface

`default_nettype wire

// File: rtl/sm_mem_arbiter.sv
// ============================================================================
// Module  : sm_mem_arbiter
// Brief   : Serialises CPU instruction-fetch and data requests onto one
//           single-ported variable-latency memory. Define SM_CONFIG_ARB_RR_EN
//           for round-robin tie-break; default is data-port priority.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sm_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          w_grantI;
    logic          w_grantD;

    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wData;
    logic [DW-1:0] r_imHold;
    logic [DW-1:0] r_dmHold;
    logic          r_err;
    logic          w_imAck;
    logic          w_dmAck;

`ifdef SM_CONFIG_ARB_RR_EN
    // 1 = data port served last; resets to D so the first tie goes to I
    logic          r_lastGrantD;
`endif

    always_comb begin
        w_nextState = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.imReq && bus.dmReq) begin
`ifdef SM_CONFIG_ARB_RR_EN
                    w_grantI = r_lastGrantD;
                    w_grantD = !r_lastGrantD;
`else
                    // M stage must drain before F to avoid pipeline deadlock
                    w_grantD = 1'b1;
`endif
                end else begin
                    w_grantI = bus.imReq;
                    w_grantD = bus.dmReq;
                end
                if (w_grantI)
                    w_nextState = BUSY_I;
                else if (w_grantD)
                    w_nextState = BUSY_D;
            end
            BUSY_I, BUSY_D: begin
                if (bus.memAck)
                    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wData <= '0;
        end else if (w_grantI) begin
            r_addr  <= bus.imAddr;
            r_we    <= 1'b0;
            r_wData <= '0;
        end else if (w_grantD) begin
            r_addr  <= bus.dmAddr;
            r_we    <= bus.dmWe;
            r_wData <= bus.dmWData;
        end
    end

`ifdef SM_CONFIG_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lastGrantD <= 1'b1;
        else if (w_grantI)
            r_lastGrantD <= 1'b0;
        else if (w_grantD)
            r_lastGrantD <= 1'b1;
    end
`endif

    assign w_imAck = bus.memAck && (r_state == BUSY_I);
    assign w_dmAck = bus.memAck && (r_state == BUSY_D);

    // Write acks also refresh the data hold register with the bus value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imHold <= '0;
            r_dmHold <= '0;
        end else begin
            if (w_imAck)
                r_imHold <= bus.memRData;
            if (w_dmAck)
                r_dmHold <= bus.memRData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (bus.memAck && (r_state == IDLE))
            r_err <= 1'b1;
    end

    assign bus.memReq   = (r_state != IDLE);
    assign bus.memWe    = r_we;
    assign bus.memAddr  = r_addr;
    assign bus.memWData = r_wData;
    assign bus.imAck    = w_imAck;
    assign bus.dmAck    = w_dmAck;
    assign bus.imData   = w_imAck ? bus.memRData : r_imHold;
    assign bus.dmRData  = w_dmAck ? bus.memRData : r_dmHold;
    assign bus.arbErr   = r_err;

endmodule

`default_nettype wire
